// File: rtl/data_memory_access_unit.sv
// MEM-stage data memory access unit: runs a req/ack transaction with data memory,
// steers store lanes, right-aligns load data and flags misaligned or timed-out accesses.
module data_memory_access_unit #(
  parameter int TIMEOUT   = 16,
  parameter int TIMEOUT_W = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        req_in,
  input  logic        write_in,
  input  logic [31:0] addr_in,
  input  logic [1:0]  size_in,
  input  logic [31:0] wdata_in,
  output logic        stall_out,
  output logic        done_out,
  output logic [31:0] rdata_out,
  output logic        misaligned_out,
  output logic        bus_error_out,
  output logic        mem_req_out,
  output logic        mem_we_out,
  output logic [31:0] mem_addr_out,
  output logic [3:0]  mem_be_out,
  output logic [31:0] mem_wdata_out,
  input  logic        mem_ack_in,
  input  logic [31:0] mem_rdata_in
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [TIMEOUT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TIMEOUT_W'(TIMEOUT - 1);

  state_t               state, state_nxt;
  logic [TIMEOUT_W-1:0] cnt;
  logic                 mis_p1, err_p1;
  logic [31:0]          addr_p1;
  logic [1:0]           size_p1;
  logic                 we_p1;
  logic [3:0]           be_p1;
  logic [31:0]          wdata_p1;
  logic                 req_mis, timeout_hit, in_access;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      2'b00:   return {4{wdata[7:0]}};
      2'b01:   return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic [31:0] align_load(input logic [1:0] size, input logic [1:0] off,
                                             input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      2'b00:   return {24'b0, sh[7:0]};
      2'b01:   return {16'b0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  assign req_mis     = is_misaligned(size_in, addr_in[1:0]);
  assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_LAST);
  assign in_access   = (state == ACCESS);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_in) state_nxt = req_mis ? DONE : ACCESS;
      ACCESS:  if (mem_ack_in || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control and load-result registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state     <= IDLE;
      cnt       <= '0;
      mis_p1    <= 1'b0;
      err_p1    <= 1'b0;
      rdata_out <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (req_in) begin
            cnt    <= '0;
            mis_p1 <= req_mis;
            err_p1 <= 1'b0;
          end
        end
        ACCESS: begin
          // Ack wins over a timeout landing in the same cycle.
          if (mem_ack_in) begin
            if (!we_p1) rdata_out <= align_load(size_p1, addr_p1[1:0], mem_rdata_in);
          end else if (timeout_hit) begin
            err_p1 <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Access fields captured on acceptance; only observed while in ACCESS
  always_ff @(posedge clk_in) begin
    if (state == IDLE && req_in && !req_mis) begin
      addr_p1  <= addr_in;
      size_p1  <= size_in;
      we_p1    <= write_in;
      be_p1    <= lane_be(size_in, addr_in[1:0]);
      wdata_p1 <= lane_data(size_in, wdata_in);
    end
  end

  assign stall_out      = in_access || (state == IDLE && req_in);
  assign done_out       = (state == DONE);
  assign misaligned_out = done_out && mis_p1;
  assign bus_error_out  = done_out && err_p1;
  assign mem_req_out    = in_access;
  assign mem_we_out     = in_access && we_p1;
  assign mem_addr_out   = in_access ? {addr_p1[31:2], 2'b00} : '0;
  assign mem_be_out     = in_access ? be_p1 : '0;
  assign mem_wdata_out  = in_access ? wdata_p1 : '0;

endmodule

// File: tb/tb_data_memory_access_unit.sv
// Bench for data_memory_access_unit: directed scenarios plus randomized accesses
// checked against a transaction-level model of lane steering, alignment and timing.
module tb_data_memory_access_unit;

  logic        clk_in = 1'b0;
  logic        rst_in, req_in, write_in;
  logic [31:0] addr_in, wdata_in;
  logic [1:0]  size_in;
  logic        stall_out, done_out, misaligned_out, bus_error_out;
  logic [31:0] rdata_out;
  logic        mem_req_out, mem_we_out;
  logic [31:0] mem_addr_out, mem_wdata_out;
  logic [3:0]  mem_be_out;
  logic        mem_ack_in;
  logic [31:0] mem_rdata_in;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_rdata = '0;

  always #5 clk_in = ~clk_in;

  data_memory_access_unit #(.TIMEOUT(16), .TIMEOUT_W(8)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .req_in(req_in), .write_in(write_in),
    .addr_in(addr_in), .size_in(size_in), .wdata_in(wdata_in),
    .stall_out(stall_out), .done_out(done_out), .rdata_out(rdata_out),
    .misaligned_out(misaligned_out), .bus_error_out(bus_error_out),
    .mem_req_out(mem_req_out), .mem_we_out(mem_we_out), .mem_addr_out(mem_addr_out),
    .mem_be_out(mem_be_out), .mem_wdata_out(mem_wdata_out),
    .mem_ack_in(mem_ack_in), .mem_rdata_in(mem_rdata_in)
  );

  // Reference model: byte count per size, enables as a contiguous run at the offset.
  function automatic int m_nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic m_mis(input logic [1:0] s, input logic [31:0] a);
    return (a % m_nbytes(s)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] s, input logic [31:0] a);
    int v;
    v = ((1 << m_nbytes(s)) - 1) << (a % 4);
    return 4'(v);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] s, input logic [31:0] wd);
    if (m_nbytes(s) == 1) return (wd % 256) * 32'h0101_0101;
    if (m_nbytes(s) == 2) return (wd % 65536) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] s, input logic [31:0] a,
                                         input logic [31:0] word);
    longint unsigned v;
    v = longint'(word) >> (8 * (a % 4));
    if (m_nbytes(s) < 4) v = v % (64'd1 << (8 * m_nbytes(s)));
    return 32'(v);
  endfunction

  task automatic idle(input int n);
    req_in = 1'b0;
    mem_ack_in = 1'b0;
    repeat (n) begin
      @(posedge clk_in); #1;
    end
  endtask

  // Presents one request and acts as memory; ack_at = ACCESS-cycle index of the ack, -1 none.
  task automatic run_txn(input logic w, input logic [31:0] a, input logic [1:0] s,
                         input logic [31:0] wd, input int ack_at, input logic [31:0] rword,
                         output int lat, output int first_req, output int req_cycles,
                         output logic [31:0] o_addr, output logic [3:0] o_be,
                         output logic [31:0] o_wdata, output logic o_we,
                         output logic o_mis, output logic o_err, output logic [31:0] o_rdata,
                         output logic o_stall0, output logic o_stall_done,
                         output logic o_unstable);
    lat = -1; first_req = -1; req_cycles = 0;
    o_addr = '0; o_be = '0; o_wdata = '0; o_we = 1'b0;
    o_mis = 1'b0; o_err = 1'b0; o_rdata = '0; o_stall_done = 1'b1; o_unstable = 1'b0;
    req_in = 1'b1; write_in = w; addr_in = a; size_in = s; wdata_in = wd;
    mem_ack_in = 1'b0;
    #1 o_stall0 = stall_out;
    for (int c = 1; c <= 100 && lat < 0; c++) begin
      @(posedge clk_in); #1;
      mem_ack_in = 1'b0;
      mem_rdata_in = $urandom;
      if (done_out) begin
        lat = c;
        o_mis = misaligned_out;
        o_err = bus_error_out;
        o_rdata = rdata_out;
        o_stall_done = stall_out;
        req_in = 1'b0;
      end else if (mem_req_out) begin
        if (req_cycles == 0) begin
          first_req = c;
          o_addr = mem_addr_out; o_be = mem_be_out; o_wdata = mem_wdata_out; o_we = mem_we_out;
        end else if (o_addr !== mem_addr_out || o_be !== mem_be_out ||
                     o_wdata !== mem_wdata_out || o_we !== mem_we_out) begin
          o_unstable = 1'b1;
        end
        if (req_cycles == ack_at) begin
          mem_ack_in = 1'b1;
          mem_rdata_in = rword;
        end
        req_cycles++;
      end
    end
    req_in = 1'b0;
    mem_ack_in = 1'b0;
  endtask

  int          lat, fr, rc;
  logic [31:0] oa, ow, ord;
  logic [3:0]  obe;
  logic        owe, omis, oerr, ost0, ostd, ounst;

  task automatic test_reset;
    rst_in = 1'b1; req_in = 1'b0; write_in = 1'b0; addr_in = '0; size_in = '0;
    wdata_in = '0; mem_ack_in = 1'b0; mem_rdata_in = '0;
    repeat (2) @(posedge clk_in);
    #1;
    total++;
    if ({stall_out, done_out, misaligned_out, bus_error_out, mem_req_out, mem_we_out} !== 6'b0 ||
        rdata_out !== 32'h0 || mem_addr_out !== 32'h0 || mem_be_out !== 4'h0 ||
        mem_wdata_out !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs: got ctl=%b rdata=%h addr=%h be=%b wdata=%h want all zero",
               {stall_out, done_out, misaligned_out, bus_error_out, mem_req_out, mem_we_out},
               rdata_out, mem_addr_out, mem_be_out, mem_wdata_out);
    end
    rst_in = 1'b0;
    idle(1);
    total++;
    if (done_out !== 1'b0 || stall_out !== 1'b0) begin
      bad++; $display("FAIL reset_idle: got done=%b stall=%b want 0 0", done_out, stall_out);
    end
  endtask

  task automatic test_byte_load;
    run_txn(1'b0, 32'h1003, 2'b00, 32'h0, 0, 32'hA1B2C3D4,
            lat, fr, rc, oa, obe, ow, owe, omis, oerr, ord, ost0, ostd, ounst);
    exp_rdata = 32'h0000_00A1;
    total++; if (ost0 !== 1'b1) begin bad++; $display("FAIL bl_stall_req: got %b want 1", ost0); end
    total++; if (oa !== 32'h1000) begin bad++; $display("FAIL bl_addr: got %h want 00001000", oa); end
    total++; if (obe !== 4'b1000) begin bad++; $display("FAIL bl_be: got %b want 1000", obe); end
    total++; if (owe !== 1'b0) begin bad++; $display("FAIL bl_we: got %b want 0", owe); end
    total++; if (lat != 2) begin bad++; $display("FAIL bl_latency: got %0d want 2", lat); end
    total++; if (ord !== exp_rdata) begin bad++; $display("FAIL bl_rdata: got %h want %h", ord, exp_rdata); end
    total++; if (ostd !== 1'b0) begin bad++; $display("FAIL bl_stall_done: got %b want 0", ostd); end
    idle(1);
    total++; if (done_out !== 1'b0) begin bad++; $display("FAIL bl_done_pulse: got %b want 0", done_out); end
  endtask

  task automatic test_half_store;
    run_txn(1'b1, 32'h2002, 2'b01, 32'h0000_BEEF, 1, 32'h5555_5555,
            lat, fr, rc, oa, obe, ow, owe, omis, oerr, ord, ost0, ostd, ounst);
    total++; if (owe !== 1'b1) begin bad++; $display("FAIL hs_we: got %b want 1", owe); end
    total++; if (obe !== 4'b1100) begin bad++; $display("FAIL hs_be: got %b want 1100", obe); end
    total++; if (ow !== 32'hBEEF_BEEF) begin bad++; $display("FAIL hs_wdata: got %h want beefbeef", ow); end
    total++; if (oa !== 32'h2000) begin bad++; $display("FAIL hs_addr: got %h want 00002000", oa); end
    total++; if (ord !== exp_rdata) begin bad++; $display("FAIL hs_rdata_held: got %h want %h", ord, exp_rdata); end
    total++; if (lat != 3) begin bad++; $display("FAIL hs_latency: got %0d want 3", lat); end
    idle(1);
  endtask

  task automatic test_misaligned;
    run_txn(1'b0, 32'h3001, 2'b11, 32'h0, 0, 32'h0,
            lat, fr, rc, oa, obe, ow, owe, omis, oerr, ord, ost0, ostd, ounst);
    total++; if (rc != 0) begin bad++; $display("FAIL mw_no_req: got %0d req cycles want 0", rc); end
    total++; if (lat != 1) begin bad++; $display("FAIL mw_latency: got %0d want 1", lat); end
    total++; if (omis !== 1'b1) begin bad++; $display("FAIL mw_flag: got %b want 1", omis); end
    total++; if (ost0 !== 1'b1) begin bad++; $display("FAIL mw_stall: got %b want 1", ost0); end
    idle(1);
    total++;
    if (misaligned_out !== 1'b0 || done_out !== 1'b0) begin
      bad++; $display("FAIL mw_flag_clear: got mis=%b done=%b want 0 0", misaligned_out, done_out);
    end
    run_txn(1'b0, 32'h3001, 2'b01, 32'h0, 0, 32'h0,
            lat, fr, rc, oa, obe, ow, owe, omis, oerr, ord, ost0, ostd, ounst);
    total++; if (omis !== 1'b1 || rc != 0) begin bad++; $display("FAIL mh_flag: got mis=%b req=%0d want 1 0", omis, rc); end
    idle(1);
    run_txn(1'b0, 32'h3001, 2'b00, 32'h0, 0, 32'h1122_3344,
            lat, fr, rc, oa, obe, ow, owe, omis, oerr, ord, ost0, ostd, ounst);
    exp_rdata = 32'h0000_0033;
    total++; if (omis !== 1'b0 || lat != 2) begin bad++; $display("FAIL mb_proceeds: got mis=%b lat=%0d want 0 2", omis, lat); end
    total++; if (ord !== exp_rdata || obe !== 4'b0010) begin bad++; $display("FAIL mb_data: got rdata=%h be=%b want %h 0010", ord, obe, exp_rdata); end
    idle(1);
  endtask

  task automatic test_timeout;
    run_txn(1'b0, 32'h4000, 2'b11, 32'h0, -1, 32'h0,
            lat, fr, rc, oa, obe, ow, owe, omis, oerr, ord, ost0, ostd, ounst);
    total++; if (rc != 16) begin bad++; $display("FAIL to_req_cycles: got %0d want 16", rc); end
    total++; if (oerr !== 1'b1 || lat != 17) begin bad++; $display("FAIL to_error: got err=%b lat=%0d want 1 17", oerr, lat); end
    total++; if (ord !== exp_rdata) begin bad++; $display("FAIL to_rdata_held: got %h want %h", ord, exp_rdata); end
    idle(1);
    total++; if (bus_error_out !== 1'b0) begin bad++; $display("FAIL to_flag_clear: got %b want 0", bus_error_out); end
    run_txn(1'b0, 32'h4000, 2'b11, 32'h0, 15, 32'hCAFE_F00D,
            lat, fr, rc, oa, obe, ow, owe, omis, oerr, ord, ost0, ostd, ounst);
    exp_rdata = 32'hCAFE_F00D;
    total++; if (oerr !== 1'b0 || rc != 16) begin bad++; $display("FAIL to_ack_wins: got err=%b req=%0d want 0 16", oerr, rc); end
    total++; if (ord !== exp_rdata) begin bad++; $display("FAIL to_ack_data: got %h want %h", ord, exp_rdata); end
    idle(1);
  endtask

  task automatic test_reset_mid;
    req_in = 1'b1; write_in = 1'b0; addr_in = 32'h5000; size_in = 2'b11;
    repeat (3) begin @(posedge clk_in); #1; end
    total++; if (mem_req_out !== 1'b1) begin bad++; $display("FAIL rm_in_access: got %b want 1", mem_req_out); end
    rst_in = 1'b1; req_in = 1'b0;
    #1;
    total++;
    if ({mem_req_out, stall_out, done_out, mem_we_out} !== 4'b0 || rdata_out !== 32'h0 ||
        mem_addr_out !== 32'h0 || mem_be_out !== 4'h0) begin
      bad++;
      $display("FAIL rm_async: got ctl=%b rdata=%h addr=%h be=%b want all zero",
               {mem_req_out, stall_out, done_out, mem_we_out}, rdata_out, mem_addr_out, mem_be_out);
    end
    exp_rdata = '0;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    mem_ack_in = 1'b1; mem_rdata_in = 32'hDEAD_BEEF;
    @(posedge clk_in); #1;
    mem_ack_in = 1'b0;
    total++;
    if (done_out !== 1'b0 || rdata_out !== 32'h0 || mem_req_out !== 1'b0) begin
      bad++; $display("FAIL rm_late_ack: got done=%b rdata=%h req=%b want 0 0 0", done_out, rdata_out, mem_req_out);
    end
    run_txn(1'b0, 32'h5004, 2'b11, 32'h0, 1, 32'h0BAD_F00D,
            lat, fr, rc, oa, obe, ow, owe, omis, oerr, ord, ost0, ostd, ounst);
    exp_rdata = 32'h0BAD_F00D;
    total++; if (lat != 3 || fr != 1) begin bad++; $display("FAIL rm_restart: got lat=%0d first_req=%0d want 3 1", lat, fr); end
    total++; if (ord !== exp_rdata) begin bad++; $display("FAIL rm_restart_data: got %h want %h", ord, exp_rdata); end
    idle(1);
  endtask

  task automatic test_back_to_back;
    run_txn(1'b0, 32'h6000, 2'b11, 32'h0, 0, 32'h1111_2222,
            lat, fr, rc, oa, obe, ow, owe, omis, oerr, ord, ost0, ostd, ounst);
    total++; if (lat != 2) begin bad++; $display("FAIL bb_first_lat: got %0d want 2", lat); end
    // Second request presented during the DONE cycle of the first.
    run_txn(1'b0, 32'h6006, 2'b01, 32'h0, 0, 32'h3344_5566,
            lat, fr, rc, oa, obe, ow, owe, omis, oerr, ord, ost0, ostd, ounst);
    exp_rdata = 32'h0000_3344;
    total++; if (ost0 !== 1'b0) begin bad++; $display("FAIL bb_done_stall: got %b want 0", ost0); end
    total++; if (fr != 2) begin bad++; $display("FAIL bb_req_gap: got %0d want 2", fr); end
    total++; if (lat != 3) begin bad++; $display("FAIL bb_second_lat: got %0d want 3", lat); end
    total++; if (oa !== 32'h6004 || ord !== exp_rdata) begin bad++; $display("FAIL bb_second_data: got addr=%h rdata=%h want 00006004 %h", oa, ord, exp_rdata); end
    idle(1);
  endtask

  task automatic test_random;
    logic        w, mis, tmo;
    logic [31:0] a, wd, rw;
    logic [1:0]  s;
    int          ack_at, r, e_lat, e_rc;
    for (int i = 0; i < 40; i++) begin
      w = 1'(($urandom % 2));
      s = 2'($urandom % 4);
      a = $urandom;
      wd = $urandom;
      rw = $urandom;
      r = $urandom_range(0, 9);
      if (r < 7) ack_at = $urandom_range(0, 4);
      else if (r == 7) ack_at = -1;
      else if (r == 8) ack_at = 15;
      else ack_at = $urandom_range(5, 14);
      mis = m_mis(s, a);
      tmo = !mis && (ack_at < 0);
      e_lat = mis ? 1 : (tmo ? 17 : ack_at + 2);
      e_rc  = mis ? 0 : (tmo ? 16 : ack_at + 1);
      if (!mis && !tmo && !w) exp_rdata = m_load(s, a, rw);
      run_txn(w, a, s, wd, ack_at, rw, lat, fr, rc, oa, obe, ow, owe, omis, oerr, ord, ost0, ostd, ounst);
      total++;
      if (lat != e_lat || rc != e_rc || omis !== mis || oerr !== tmo) begin
        bad++;
        $display("FAIL rnd_ctl[%0d]: got lat=%0d req=%0d mis=%b err=%b want %0d %0d %b %b",
                 i, lat, rc, omis, oerr, e_lat, e_rc, mis, tmo);
      end
      total++;
      if (ord !== exp_rdata) begin
        bad++; $display("FAIL rnd_rdata[%0d]: got %h want %h", i, ord, exp_rdata);
      end
      if (!mis) begin
        total++;
        if (oa !== (a & 32'hFFFF_FFFC) || obe !== m_be(s, a) || owe !== w ||
            ow !== m_wdata(s, wd) || ounst !== 1'b0) begin
          bad++;
          $display("FAIL rnd_bus[%0d]: got addr=%h be=%b we=%b wdata=%h unstable=%b want %h %b %b %h 0",
                   i, oa, obe, owe, ow, ounst, a & 32'hFFFF_FFFC, m_be(s, a), w, m_wdata(s, wd));
        end
      end
      idle(1);
      total++;
      if (done_out !== 1'b0) begin bad++; $display("FAIL rnd_done_pulse[%0d]: got %b want 0", i, done_out); end
    end
  endtask

  initial begin
    test_reset();
    test_byte_load();
    test_half_store();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
